// File: rtl/seg_monitor.sv
// seg_monitor: receives the decade counter's 7-segment display bus, decodes
// each pattern captured on a rising edge of the divided tick, and checks the
// digit sequence against the selected count mode (up/down/hold/track-only).
// Reports lock, wrap and error events.
// Optional feature macro: SEGMON_ERRCNT_EN builds the saturating error counter;
// without it err_count is tied to zero.
module seg_monitor #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [6:0]       i_display,
    input  logic             i_tick,
    input  logic [1:0]       mode,
    output logic [3:0]       oQ,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_err,
    output logic             o_wrap,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [0:0] {StIdle, StTrack} state_e;

    state_e     state_q;
    logic       tick_d;
    logic       sample_q;
    logic [6:0] disp_q;
    logic [1:0] mode_q;
    logic [1:0] last_mode_q;
    logic [3:0] prev_q;

    logic [3:0] dig;
    logic       dig_ok;
    logic [3:0] exp_dig;
    logic       check_en;
    logic       match;
    logic       wrap_hit;
    logic       err_now;

    // Decode the captured active-low gfedcba pattern; 4'hF marks invalid
    always_comb begin
        dig = 4'hF;
        case (disp_q)
            7'h40:   dig = 4'd0;
            7'h79:   dig = 4'd1;
            7'h24:   dig = 4'd2;
            7'h30:   dig = 4'd3;
            7'h19:   dig = 4'd4;
            7'h12:   dig = 4'd5;
            7'h02:   dig = 4'd6;
            7'h78:   dig = 4'd7;
            7'h00:   dig = 4'd8;
            7'h10:   dig = 4'd9;
            default: dig = 4'hF;
        endcase
    end

    // Expected digit for this sample and the check/wrap/error decisions
    always_comb begin
        exp_dig = prev_q;
        case (mode_q)
            2'b00:   exp_dig = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
            2'b01:   exp_dig = (prev_q == 4'd0) ? 4'd9 : prev_q - 4'd1;
            default: exp_dig = prev_q;
        endcase
        dig_ok   = (dig != 4'hF);
        // A mode change since the last sample skips exactly one compare
        check_en = (state_q == StTrack) && (mode_q == last_mode_q) && (mode_q != 2'b11);
        match    = (dig == exp_dig);
        wrap_hit = check_en && match &&
                   (((mode_q == 2'b00) && (prev_q == 4'd9)) ||
                    ((mode_q == 2'b01) && (prev_q == 4'd0)));
        err_now  = sample_q && (!dig_ok || (check_en && !match));
    end

    // Tick edge capture, sequence FSM and registered event outputs
    always_ff @(posedge CLK) begin
        if (rst) begin
            // tick_d resets high so a tick already high at release is not a sample
            tick_d      <= 1'b1;
            sample_q    <= 1'b0;
            disp_q      <= 7'h7F;
            mode_q      <= 2'b00;
            last_mode_q <= 2'b00;
            prev_q      <= 4'd0;
            state_q     <= StIdle;
            oQ          <= 4'd0;
            o_valid     <= 1'b0;
            o_lock      <= 1'b0;
            o_err       <= 1'b0;
            o_wrap      <= 1'b0;
        end else begin
            tick_d   <= i_tick;
            sample_q <= i_tick & ~tick_d;
            if (i_tick & ~tick_d) begin
                disp_q <= i_display;
                mode_q <= mode;
            end
            o_valid <= 1'b0;
            o_err   <= err_now;
            o_wrap  <= 1'b0;
            if (sample_q) begin
                o_valid     <= 1'b1;
                oQ          <= dig;
                last_mode_q <= mode_q;
                case (state_q)
                    StIdle: begin
                        if (dig_ok) begin
                            state_q <= StTrack;
                            o_lock  <= 1'b1;
                            prev_q  <= dig;
                        end
                    end
                    StTrack: begin
                        if (!dig_ok) begin
                            state_q <= StIdle;
                            o_lock  <= 1'b0;
                        end else begin
                            // Mismatches resynchronise to the new digit too
                            prev_q <= dig;
                            o_wrap <= wrap_hit;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef SEGMON_ERRCNT_EN
    // Saturating count of error pulses
    always_ff @(posedge CLK) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_now && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
